// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared seven-segment constants.
//   HEX_SEG   : 16-entry active-low glyph table, bit6=a .. bit0=g, index = nibble
//   SEG_DASH  : centre bar only (g lit), shown while no request is active
//   SEG_BLANK : all segments dark, shown while in reset
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed so that HEX_SEG[n] is the glyph for nibble n (entry F listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage : seg_pkg

// File: rtl/hex_seg.sv
// ---------------------------------------------------------------------------
// hex_seg -- combinational nibble to seven-segment glyph lookup.
//   nibble_i : 4-bit value to display
//   seg_o    : active-low segment pattern, bit6=a .. bit0=g
// ---------------------------------------------------------------------------
module hex_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule : hex_seg

// File: rtl/prio_enc_scan.sv
// ---------------------------------------------------------------------------
// prio_enc_scan -- registered priority encoder with a multiplexed hex display.
//   clk       : single clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   x         : request vector (W bits)
//   en        : encoder enable
//   lsb_first : 0 = highest set bit wins, 1 = lowest set bit wins
//   idx       : winning bit position, 0 when nothing wins
//   flag      : 1 iff enabled and any request bit set
//   chg       : one-cycle pulse in the cycle a new {flag,idx} first appears
//   seg       : active-low segments of the currently selected digit
//   an        : active-low one-hot digit select (NDIG bits)
// Pipeline: inputs are registered (cycle 1), encoded result is registered
// (cycle 2). The scan display reads the registered result, so a new value
// shows up mid-scan without disturbing the scan counter or digit pointer.
// ---------------------------------------------------------------------------
module prio_enc_scan
  import seg_pkg::*;
#(
  parameter int W        = 8,
  parameter int NDIG     = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         x,
  input  logic                 en,
  input  logic                 lsb_first,
  output logic [$clog2(W)-1:0] idx,
  output logic                 flag,
  output logic                 chg,
  output logic [6:0]           seg,
  output logic [NDIG-1:0]      an
);

  localparam int IW = $clog2(W);
  localparam int NW = NDIG * 4;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  // The display must be wide enough to show every possible index.
  if (W < 2 || W > 64 || NDIG < 1 || SCAN_DIV < 1 || NW < IW) begin : g_bad_param
    $error("prio_enc_scan: illegal parameters W=%0d NDIG=%0d SCAN_DIV=%0d",
           W, NDIG, SCAN_DIV);
  end

  // ---------------- input stage ----------------
  logic [W-1:0] x_q;
  logic         en_q;
  logic         lsb_q;

  // NOTE: state is written with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      en_q  <= 1'b0;
      lsb_q <= 1'b0;
    end else begin
      x_q   <= x;
      en_q  <= en;
      lsb_q <= lsb_first;
    end
  end

  // ---------------- priority encoder ----------------
  logic [IW-1:0] enc_idx;
  logic [IW-1:0] idx_d, idx_q;
  logic          flag_d, flag_q;
  logic          chg_d, chg_q;

  // NOTE: every variable gets a default before any conditional code, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    enc_idx = '0;
    // Later loop iterations overwrite earlier ones, so the scan direction
    // decides which set bit survives.
    if (lsb_q) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (x_q[i]) enc_idx = IW'(i);
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (x_q[i]) enc_idx = IW'(i);
      end
    end
    flag_d = en_q && (x_q != '0);
    idx_d  = flag_d ? enc_idx : '0;
    // Compared against the registered value, so a mode toggle that yields the
    // same winner produces no pulse.
    chg_d  = ({flag_d, idx_d} != {flag_q, idx_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      flag_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      flag_q <= flag_d;
      chg_q  <= chg_d;
    end
  end

  // ---------------- display scan ----------------
  logic [CW-1:0]   cnt_d, cnt_q;
  logic [DW-1:0]   dig_d, dig_q;
  logic            cnt_wrap;
  logic [NW-1:0]   idx_ext;
  logic [3:0]      nibble;
  logic [6:0]      hex_pat;
  logic [6:0]      seg_d, seg_q;
  logic [NDIG-1:0] an_d, an_q;

  always_comb begin
    cnt_wrap = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    dig_d    = dig_q;
    if (cnt_wrap) begin
      dig_d = (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + DW'(1);
    end

    idx_ext = NW'(idx_q);
    nibble  = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_q == DW'(i)) nibble = idx_ext[i*4 +: 4];
    end

    seg_d = flag_q ? hex_pat : SEG_DASH;
    an_d  = ~(NDIG'(1) << dig_q);
  end

  hex_seg u_hex_seg (
    .nibble_i (nibble),
    .seg_o    (hex_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign idx  = idx_q;
  assign flag = flag_q;
  assign chg  = chg_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule : prio_enc_scan

// File: tb/tb_prio_enc_scan.sv
// ---------------------------------------------------------------------------
// tb_prio_enc_scan -- scoreboard bench for prio_enc_scan.
// Three instances share clock and reset:
//   u_dut8  : W=8,  NDIG=2, SCAN_DIV=3  -- driven with a stimulus sequence
//   u_dut32 : W=32, NDIG=2, SCAN_DIV=4  -- fixed x = 1<<27, display check
//   u_dut4  : W=4,  NDIG=1, SCAN_DIV=1  -- fixed x = 4'b0110, degenerate scan
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_prio_enc_scan;

  localparam int SD8  = 3;
  localparam int SD32 = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  x8   = '0;
  logic        en8  = 1'b0;
  logic        lsb8 = 1'b0;
  logic [2:0]  idx8;
  logic        flag8, chg8;
  logic [6:0]  seg8;
  logic [1:0]  an8;

  logic [31:0] x32 = 32'h0800_0000;
  logic [4:0]  idx32;
  logic        flag32, chg32;
  logic [6:0]  seg32;
  logic [1:0]  an32;

  logic [3:0]  x4 = 4'b0110;
  logic [1:0]  idx4;
  logic        flag4, chg4;
  logic [6:0]  seg4;
  logic        an4;

  prio_enc_scan #(.W(8), .NDIG(2), .SCAN_DIV(SD8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .x(x8), .en(en8), .lsb_first(lsb8),
    .idx(idx8), .flag(flag8), .chg(chg8), .seg(seg8), .an(an8)
  );

  prio_enc_scan #(.W(32), .NDIG(2), .SCAN_DIV(SD32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .x(x32), .en(1'b1), .lsb_first(1'b0),
    .idx(idx32), .flag(flag32), .chg(chg32), .seg(seg32), .an(an32)
  );

  prio_enc_scan #(.W(4), .NDIG(1), .SCAN_DIV(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .en(1'b1), .lsb_first(1'b0),
    .idx(idx4), .flag(flag4), .chg(chg4), .seg(seg4), .an(an4)
  );

  typedef struct packed {
    logic       flag;
    logic [2:0] idx;
    logic       chg;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] prev_val = '0;  // last expected {flag,idx}, for the chg model
  logic [3:0] disp_val = '0;  // {flag,idx} the display was built from
  int         k        = 0;   // rising edges since reset release
  int         n_cmp    = 0;
  int         n_bad    = 0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Returns {flag, idx[2:0]} for the 8-bit instance.
  function automatic logic [3:0] model(input logic [7:0] x, input logic en,
                                       input logic lsb);
    int pos = -1;
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        int j = lsb ? i : 7 - i;
        if (pos < 0 && x[j]) pos = j;
      end
    end
    return (pos < 0) ? 4'b0000 : {1'b1, 3'(pos)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_idx8"},  idx8,  0);
    check({tag, "_flag8"}, flag8, 0);
    check({tag, "_chg8"},  chg8,  0);
    check({tag, "_seg8"},  seg8,  7'b1111111);
    check({tag, "_an8"},   an8,   2'b11);
    check({tag, "_seg32"}, seg32, 7'b1111111);
    check({tag, "_an32"},  an32,  2'b11);
    check({tag, "_an4"},   an4,   1'b1);
  endtask

  // Called on a falling edge: check outputs of the last rising edge, drive
  // the next input, advance one cycle.
  task automatic step(input logic [7:0] x, input logic en, input logic lsb);
    exp_t       e;
    logic [3:0] v;
    int         dig;
    if (k >= 1) begin
      dig = ((k - 1) / SD8) % 2;
      check("an8", an8, (dig == 0) ? 2'b10 : 2'b01);
      check("seg8", seg8, disp_val[3] ?
            hex7((dig == 0) ? {1'b0, disp_val[2:0]} : 4'h0) : 7'b1111110);
      dig = ((k - 1) / SD32) % 2;
      check("an32", an32, (dig == 0) ? 2'b10 : 2'b01);
      check("an4", an4, 1'b0);
    end
    if (k == 1) begin
      check("rel_idx8",  idx8,  0);
      check("rel_flag8", flag8, 0);
      check("rel_chg8",  chg8,  0);
    end
    if (k >= 2) begin
      check("idx32",  idx32,  27);
      check("flag32", flag32, 1);
      check("chg32",  chg32,  (k == 2));
      check("idx4",   idx4,   2);
      check("flag4",  flag4,  1);
      check("chg4",   chg4,   (k == 2));
    end
    if (k >= 3) begin
      dig = ((k - 1) / SD32) % 2;
      check("seg32", seg32, (dig == 0) ? 7'b1100000 : 7'b1001111);
      check("seg4",  seg4,  7'b0010010);
    end

    disp_val = '0;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check("idx8",  idx8,  e.idx);
      check("flag8", flag8, e.flag);
      check("chg8",  chg8,  e.chg);
      disp_val = {e.flag, e.idx};
    end

    v      = model(x, en, lsb);
    e.flag = v[3];
    e.idx  = v[2:0];
    e.chg  = (v != prev_val);
    prev_val = v;
    sb.push_back(e);

    x8   = x;
    en8  = en;
    lsb8 = lsb;
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] x, input logic en, input logic lsb,
                      input int n);
    for (int i = 0; i < n; i++) step(x, en, lsb);
  endtask

  initial begin
    @(negedge clk);
    check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    hold(8'h00, 1'b1, 1'b0, 2);
    hold(8'h2C, 1'b1, 1'b0, 8);    // highest bit -> 5
    hold(8'h2C, 1'b1, 1'b1, 8);    // lowest bit -> 2
    hold(8'h10, 1'b1, 1'b0, 3);    // single bit: mode toggle changes nothing
    hold(8'h10, 1'b1, 1'b1, 3);
    hold(8'h00, 1'b1, 1'b1, 8);    // no request -> flag 0, dashes
    hold(8'hFF, 1'b0, 1'b0, 12);   // disabled -> no flag, no chg
    hold(8'h81, 1'b1, 1'b0, 4);    // -> 7
    hold(8'h81, 1'b1, 1'b1, 4);    // bit 0 wins with flag set
    hold(8'h01, 1'b1, 1'b0, 3);
    for (int i = 0; i < 24; i++) begin
      step(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Reset mid-scan with idx = 7.
    hold(8'h80, 1'b1, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    sb.delete();
    prev_val = '0;
    disp_val = '0;
    k = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hold(8'h80, 1'b1, 1'b0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_prio_enc_scan
